// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending types: amount width, coin values, dispenser states
package vend_pkg;

  localparam int AMOUNT_W = 5;
  localparam int COUNT_W  = 5;

  localparam int COIN_10 = 10;
  localparam int COIN_5  = 5;
  localparam int COIN_1  = 1;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - combinational greedy coin chooser over 10/5/1 with empty-hopper fallback
module coin_select
  import vend_pkg::*;
(
  input  logic [AMOUNT_W-1:0] remaining,
  input  logic                empty_10,
  input  logic                empty_5,
  input  logic                empty_1,
  output logic [2:0]          sel_onehot,
  output logic [AMOUNT_W-1:0] sel_value,
  output logic                none_avail
);

  // sel_onehot bit 2 = 10-unit, bit 1 = 5-unit, bit 0 = 1-unit
  always_comb begin
    sel_onehot = 3'b000;
    sel_value  = '0;
    none_avail = 1'b0;
    if (!empty_10 && (remaining >= AMOUNT_W'(COIN_10))) begin
      sel_onehot = 3'b100;
      sel_value  = AMOUNT_W'(COIN_10);
    end else if (!empty_5 && (remaining >= AMOUNT_W'(COIN_5))) begin
      sel_onehot = 3'b010;
      sel_value  = AMOUNT_W'(COIN_5);
    end else if (!empty_1 && (remaining >= AMOUNT_W'(COIN_1))) begin
      sel_onehot = 3'b001;
      sel_value  = AMOUNT_W'(COIN_1);
    end else begin
      none_avail = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change as timed hopper strokes, greedy 10/5/1 with fallback
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] change_amount,
  input  logic                empty_10,
  input  logic                empty_5,
  input  logic                empty_1,
  output logic                coin_10_out,
  output logic                coin_5_out,
  output logic                coin_1_out,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [AMOUNT_W-1:0] remaining,
  output logic [COUNT_W-1:0]  coin_count
);

  localparam int CNT_MAX = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  disp_state_e         state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          coin_sel;
  logic [AMOUNT_W-1:0] coin_val;

  logic [2:0]          sel_onehot;
  logic [AMOUNT_W-1:0] sel_value;
  logic                none_avail;

  coin_select u_coin_select (
    .remaining  (remaining),
    .empty_10   (empty_10),
    .empty_5    (empty_5),
    .empty_1    (empty_1),
    .sel_onehot (sel_onehot),
    .sel_value  (sel_value),
    .none_avail (none_avail)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (change_amount == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: next_state = none_avail ? ST_FAULT : ST_PULSE;
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          next_state = (remaining == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_FAULT: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Strokes decode straight from state so an async reset drops them at once
  always_comb begin
    coin_10_out = (state == ST_PULSE) && coin_sel[2];
    coin_5_out  = (state == ST_PULSE) && coin_sel[1];
    coin_1_out  = (state == ST_PULSE) && coin_sel[0];
    busy        = (state == ST_SELECT) || (state == ST_PULSE) || (state == ST_GAP);
    done        = (state == ST_DONE);
    error       = (state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      coin_sel   <= 3'b000;
      coin_val   <= '0;
      remaining  <= '0;
      coin_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            remaining  <= change_amount;
            coin_count <= '0;
          end
        end
        ST_SELECT: begin
          // Hopper flags are frozen here for the whole stroke
          coin_sel <= sel_onehot;
          coin_val <= sel_value;
          cnt      <= '0;
        end
        ST_PULSE: begin
          if (cnt == PULSE_LAST) begin
            remaining <= remaining - coin_val;
            if (coin_count != COUNT_MAX) begin
              coin_count <= coin_count + 1'b1;
            end
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          cnt <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;
  import vend_pkg::*;

  logic                clk;
  logic                reset;
  logic                start;
  logic [AMOUNT_W-1:0] change_amount;
  logic                empty_10, empty_5, empty_1;
  logic                coin_10_out, coin_5_out, coin_1_out;
  logic                busy, done, error;
  logic [AMOUNT_W-1:0] remaining;
  logic [COUNT_W-1:0]  coin_count;

  int vectors = 0;
  int miscompares = 0;

  int   seq[$];
  int   widths[$];
  int   done_cnt, err_cnt, done_cyc, err_cyc, overlap, first_coin_cyc;
  logic busy1, busy_end;

  change_dispenser #(.PULSE_WIDTH(2), .GAP_CYCLES(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .change_amount (change_amount),
    .empty_10      (empty_10),
    .empty_5       (empty_5),
    .empty_1       (empty_1),
    .coin_10_out   (coin_10_out),
    .coin_5_out    (coin_5_out),
    .coin_1_out    (coin_1_out),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .remaining     (remaining),
    .coin_count    (coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int denom(input logic [2:0] v);
    case (v)
      3'b100:  return 10;
      3'b010:  return 5;
      3'b001:  return 1;
      default: return 99;
    endcase
  endfunction

  // Cycle k = negedge following the k-th rising edge, the start-sampling edge being k=1
  task automatic run_payout(input int amt, input logic z10, input logic z5, input logic z1,
                            input int inj_cyc, input int inj_amt);
    logic [2:0] cur, prev;
    int end_cyc;
    seq.delete();
    widths.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    overlap = 0; first_coin_cyc = -1; end_cyc = -1;
    busy1 = 1'b0; busy_end = 1'b1; prev = 3'b000;
    @(negedge clk);
    empty_10 = z10; empty_5 = z5; empty_1 = z1;
    change_amount = AMOUNT_W'(amt);
    start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == inj_cyc) begin
        start = 1'b1;
        change_amount = AMOUNT_W'(inj_amt);
      end
      if (k == inj_cyc + 1) start = 1'b0;
      cur = {coin_10_out, coin_5_out, coin_1_out};
      if ($countones(cur) > 1) overlap++;
      if (cur != 3'b000 && cur != prev) begin
        seq.push_back(denom(cur));
        widths.push_back(1);
        if (first_coin_cyc < 0) first_coin_cyc = k;
      end else if (cur != 3'b000) begin
        widths[widths.size()-1] = widths[widths.size()-1] + 1;
      end
      prev = cur;
      if (k == 1) busy1 = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        busy_end = busy;
      end
      if (error) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = k;
        busy_end = busy;
      end
      if (end_cyc < 0 && (done || error)) end_cyc = k;
      if (end_cyc >= 0 && k >= end_cyc + 2) break;
    end
    if (end_cyc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL payout_timeout amount=%0d: no done/error within 80 cycles", amt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; change_amount = '0;
    empty_10 = 1'b0; empty_5 = 1'b0; empty_1 = 1'b0;
    #3;
    vectors++;
    if ({coin_10_out, coin_5_out, coin_1_out, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b expected 000000",
               {coin_10_out, coin_5_out, coin_1_out, busy, done, error});
    end
    vectors++;
    if (remaining !== '0 || coin_count !== '0) begin
      miscompares++;
      $display("FAIL reset_counters got rem=%0d cnt=%0d expected 0/0", remaining, coin_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_amount_15();
    run_payout(15, 1'b0, 1'b0, 1'b0, -10, 0);
    vectors++;
    if (seq.size() != 2 || seq[0] != 10 || seq[1] != 5) begin
      miscompares++;
      $display("FAIL amt15_sequence got size %0d expected 10,5", seq.size());
    end
    for (int i = 0; i < widths.size(); i++) begin
      vectors++;
      if (widths[i] != 2) begin
        miscompares++;
        $display("FAIL amt15_width[%0d] got %0d expected 2", i, widths[i]);
      end
    end
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL amt15_busy_after_start got %b expected 1", busy1);
    end
    vectors++;
    if (first_coin_cyc != 2) begin
      miscompares++;
      $display("FAIL amt15_first_coin_cycle got %0d expected 2", first_coin_cyc);
    end
    vectors++;
    if (done_cyc != 9 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL amt15_done got cycle %0d count %0d expected 9/1", done_cyc, done_cnt);
    end
    vectors++;
    if (busy_end !== 1'b0) begin
      miscompares++;
      $display("FAIL amt15_busy_at_done got %b expected 0", busy_end);
    end
    vectors++;
    if (coin_count !== 5'd2 || remaining !== '0) begin
      miscompares++;
      $display("FAIL amt15_final got cnt=%0d rem=%0d expected 2/0", coin_count, remaining);
    end
  endtask

  task automatic test_amount_27();
    int exp_seq[5] = '{10, 10, 5, 1, 1};
    run_payout(27, 1'b0, 1'b0, 1'b0, -10, 0);
    vectors++;
    if (seq.size() != 5) begin
      miscompares++;
      $display("FAIL amt27_coin_total got %0d expected 5", seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seq[i] != exp_seq[i]) begin
          miscompares++;
          $display("FAIL amt27_coin[%0d] got %0d expected %0d", i, seq[i], exp_seq[i]);
        end
      end
    end
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL amt27_overlap got %0d expected 0", overlap);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 21) begin
      miscompares++;
      $display("FAIL amt27_done got count %0d cycle %0d expected 1/21", done_cnt, done_cyc);
    end
    vectors++;
    if (coin_count !== 5'd5 || remaining !== '0) begin
      miscompares++;
      $display("FAIL amt27_final got cnt=%0d rem=%0d expected 5/0", coin_count, remaining);
    end
  endtask

  task automatic test_empty_10();
    run_payout(15, 1'b1, 1'b0, 1'b0, -10, 0);
    vectors++;
    if (seq.size() != 3 || seq[0] != 5 || seq[1] != 5 || seq[2] != 5) begin
      miscompares++;
      $display("FAIL empty10_sequence got size %0d expected 5,5,5", seq.size());
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 13 || coin_count !== 5'd3) begin
      miscompares++;
      $display("FAIL empty10_done got cycle %0d cnt %0d expected 13/3", done_cyc, coin_count);
    end
  endtask

  task automatic test_fault();
    run_payout(3, 1'b0, 1'b0, 1'b1, -10, 0);
    vectors++;
    if (err_cyc != 2 || err_cnt != 1) begin
      miscompares++;
      $display("FAIL fault_error got cycle %0d count %0d expected 2/1", err_cyc, err_cnt);
    end
    vectors++;
    if (seq.size() != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL fault_no_coins got coins %0d done %0d expected 0/0", seq.size(), done_cnt);
    end
    vectors++;
    if (remaining !== 5'd3 || busy_end !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_final got rem=%0d busy=%b expected 3/0", remaining, busy_end);
    end
  endtask

  task automatic test_zero();
    run_payout(0, 1'b0, 1'b0, 1'b0, -10, 0);
    vectors++;
    if (done_cyc != 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_done got cycle %0d count %0d expected 1/1", done_cyc, done_cnt);
    end
    vectors++;
    if (seq.size() != 0 || coin_count !== '0 || remaining !== '0) begin
      miscompares++;
      $display("FAIL zero_final got coins %0d cnt %0d rem %0d expected 0/0/0",
               seq.size(), coin_count, remaining);
    end
  endtask

  task automatic test_busy_start();
    run_payout(20, 1'b0, 1'b0, 1'b0, 3, 7);
    vectors++;
    if (seq.size() != 2 || seq[0] != 10 || seq[1] != 10) begin
      miscompares++;
      $display("FAIL busy_start_sequence got size %0d expected 10,10", seq.size());
    end
    vectors++;
    if (done_cyc != 9 || done_cnt != 1 || remaining !== '0 || coin_count !== 5'd2) begin
      miscompares++;
      $display("FAIL busy_start_final got cycle %0d rem %0d cnt %0d expected 9/0/2",
               done_cyc, remaining, coin_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    empty_10 = 1'b0; empty_5 = 1'b0; empty_1 = 1'b0;
    change_amount = AMOUNT_W'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (coin_10_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_pre_coin10 got %b expected 1", coin_10_out);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({coin_10_out, coin_5_out, coin_1_out, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async_drop got %b expected 000000",
               {coin_10_out, coin_5_out, coin_1_out, busy, done, error});
    end
    vectors++;
    if (remaining !== '0 || coin_count !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_counters got rem=%0d cnt=%0d expected 0/0", remaining, coin_count);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_pulse got done=%b error=%b expected 0/0", done, error);
    end
    reset = 1'b1;
    run_payout(5, 1'b0, 1'b0, 1'b0, -10, 0);
    vectors++;
    if (seq.size() != 1 || seq[0] != 5 || done_cyc != 5 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL mid_reset_recover got coins %0d done cycle %0d expected 1 coin_5 / 5",
               seq.size(), done_cyc);
    end
    vectors++;
    if (coin_count !== 5'd1 || remaining !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_recover_final got cnt=%0d rem=%0d expected 1/0", coin_count, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_amount_15();
    test_amount_27();
    test_empty_10();
    test_fault();
    test_zero();
    test_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
